// File: rtl/serial_adder_seq.sv
// serial_adder_seq: multi-cycle adder, DIGIT bits per clock with a rippled carry.
// start/busy/done handshake; sum/carry only ever show completed results.
module serial_adder_seq #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  localparam int K  = WIDTH / DIGIT;
  localparam int CW = $clog2(K + 1);

  if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH ||
      (WIDTH % DIGIT) != 0) begin : g_bad_params
    $error("serial_adder_seq: illegal WIDTH/DIGIT");
  end

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_q, c_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [DIGIT:0]   dsum;
  logic [WIDTH-1:0] dig_top;
  logic [WIDTH-1:0] acc_nxt;
  logic             last;

  // One digit step: low digit of each operand plus the rippled carry.
  always_comb begin
    dsum = {1'b0, a_q[DIGIT-1:0]}
         + {1'b0, b_q[DIGIT-1:0]}
         + {{DIGIT{1'b0}}, c_q};
    dig_top = WIDTH'(dsum[DIGIT-1:0]) << (WIDTH - DIGIT);
    acc_nxt = (acc_q >> DIGIT) | dig_top;
    last    = (cnt_q == CW'(K - 1));
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    c_d     = c_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          c_d     = cin;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_d   = a_q >> DIGIT;
        b_d   = b_q >> DIGIT;
        acc_d = acc_nxt;
        c_d   = dsum[DIGIT];
        cnt_d = cnt_q + 1'b1;
        if (last) begin
          sum_d   = acc_nxt;
          carry_d = dsum[DIGIT];
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      c_q     <= 1'b0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      c_q     <= c_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy  = (state_q == RUN);
  assign done  = (state_q == DONE);
  assign sum   = sum_q;
  assign carry = carry_q;

endmodule

// File: tb/tb_serial_adder_seq.sv
// tb_serial_adder_seq: several widths/digit sizes in parallel, each with a
// driver pushing expected results and a monitor popping them on done.
module tb_serial_adder_seq;

  localparam int NCFG = 6;
  localparam int WS[NCFG] = '{1, 8, 16, 8, 8, 32};
  localparam int DS[NCFG] = '{1, 1, 4, 2, 8, 4};

  logic clk = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  logic [NCFG-1:0] fin_all;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  for (genvar g = 0; g < NCFG; g++) begin : gc
    localparam int W = WS[g];
    localparam int D = DS[g];
    localparam int K = W / D;

    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         cin = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, carry;
    logic [W-1:0] sum;
    int           due_q[$];
    logic [W:0]   res_q[$];
    logic [W:0]   last_res = '0;
    int           last_due = 0;
    logic         fin = 1'b0;
    logic         e_done, e_busy;
    string        tag;

    assign fin_all[g] = fin;

    serial_adder_seq #(.WIDTH(W), .DIGIT(D)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .start(start),
      .a    (a),
      .b    (b),
      .cin  (cin),
      .busy (busy),
      .done (done),
      .sum  (sum),
      .carry(carry)
    );

    // Reference: plain unsigned addition, truncated to W+1 bits.
    function automatic logic [W:0] ref_add(input logic [31:0] av,
                                           input logic [31:0] bv,
                                           input logic cv);
      longint unsigned m, s;
      m = (64'd1 << W) - 64'd1;
      s = (64'(av) & m) + (64'(bv) & m) + 64'(cv);
      return s[W:0];
    endfunction

    task automatic step();
      @(posedge clk);
      #1;
    endtask

    task automatic idle(input int n);
      repeat (n) step();
    endtask

    task automatic issue(input logic [31:0] av, input logic [31:0] bv,
                         input logic cv);
      a = av[W-1:0];
      b = bv[W-1:0];
      cin = cv;
      start = 1'b1;
      step();
      start = 1'b0;
      res_q.push_back(ref_add(av, bv, cv));
      due_q.push_back(cyc + K);
      last_due = cyc + K;
    endtask

    // Operand inputs churn while running; they must not matter.
    task automatic run_out();
      while (cyc < last_due) begin
        a = W'($urandom);
        b = W'($urandom);
        cin = 1'($urandom);
        step();
      end
    endtask

    always @(negedge clk) begin
      if (rst_n) begin
        if (due_q.size() > 0 && due_q[0] < cyc) begin
          chk({tag, " done timeout"}, 64'(cyc), 64'(due_q[0]));
          void'(due_q.pop_front());
          void'(res_q.pop_front());
        end
        e_done = due_q.size() > 0 && due_q[0] == cyc;
        e_busy = due_q.size() > 0 && due_q[0] > cyc;
        chk({tag, " busy"}, 64'(busy), 64'(e_busy));
        chk({tag, " done"}, 64'(done), 64'(e_done));
        if (e_done) begin
          last_res = res_q.pop_front();
          void'(due_q.pop_front());
        end
        chk({tag, " result"}, 64'({carry, sum}), 64'(last_res));
      end
    end

    initial begin
      tag = $sformatf("W%0dD%0d", W, D);
      idle(2);
      chk({tag, " reset busy"}, 64'(busy), 64'd0);
      chk({tag, " reset done"}, 64'(done), 64'd0);
      chk({tag, " reset result"}, 64'({carry, sum}), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      step();

      for (int i = 0; i < 4; i++) begin
        issue(32'(i >> 1), 32'(i & 1), 1'b0);
        run_out();
        idle(1);
      end
      issue(32'h00FF, 32'h0001, 1'b0); run_out(); idle(1);
      issue(32'h00A5, 32'h005A, 1'b1); run_out(); idle(1);
      issue(32'h0012, 32'h0034, 1'b0); run_out(); idle(1);
      issue(32'h1234, 32'hEDCC, 1'b0); run_out(); idle(1);
      issue(32'h0F0F, 32'h0101, 1'b1); run_out(); idle(1);

      // Start pulse during RUN is ignored, then back-to-back issue.
      issue(32'h10, 32'h20, 1'b0);
      if (K >= 2) begin
        idle(K > 3 ? 2 : 0);
        a = '1;
        b = '1;
        start = 1'b1;
        step();
        start = 1'b0;
      end
      run_out();
      issue(32'h01, 32'h01, 1'b0);
      run_out();
      idle(2);

      // Asynchronous reset in the middle of a computation.
      issue(32'h03, 32'h04, 1'b0); run_out(); idle(2);
      issue(32'hF0, 32'h0F, 1'b0);
      idle(K > 3 ? 3 : K - 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk({tag, " midreset busy"}, 64'(busy), 64'd0);
      chk({tag, " midreset done"}, 64'(done), 64'd0);
      chk({tag, " midreset result"}, 64'({carry, sum}), 64'd0);
      due_q.delete();
      res_q.delete();
      last_res = '0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      issue(32'h01, 32'h02, 1'b0); run_out(); idle(1);

      for (int i = 0; i < 500; i++) begin
        issue($urandom, $urandom, 1'($urandom));
        run_out();
        if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
      end
      idle(3);
      chk({tag, " drain"}, 64'(due_q.size()), 64'd0);
      fin = 1'b1;
    end
  end

  initial begin
    for (int t = 0; t < 60000 && fin_all != '1; t++) @(posedge clk);
    chk("all configs finished", 64'(fin_all), 64'({NCFG{1'b1}}));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
